// File: rtl/bf16_multiplier_pipeline.sv
// bfloat16 multiplier with round-to-nearest-even: unpack, multiply, normalize, round/pack.
// Define BF16_MUL_SPECIAL_EN for Inf/NaN handling; otherwise exponent 255 is finite and overflow saturates.
module bf16_multiplier_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  input  logic        out_ready,
  output logic [15:0] result
);

  logic advance;

  // Stage 1: operands and classification
  logic        s1_valid_q;
  logic [15:0] s1_a_q, s1_b_q;
  logic        s1_zero_a_q, s1_zero_b_q;
  // Stage 2: sign, exponent sum, mantissa product
  logic              s2_valid_q, s2_sign_q, s2_zero_q;
  logic signed [9:0] s2_exp_q, s2_exp_d;
  logic [15:0]       s2_prod_q, s2_prod_d;
  // Stage 3: normalized mantissa with guard/sticky
  logic              s3_valid_q, s3_sign_q, s3_zero_q, s3_guard_q, s3_sticky_q;
  logic signed [9:0] s3_exp_q, s3_exp_d;
  logic [6:0]        s3_mant_q, s3_mant_d;
  logic              s3_guard_d, s3_sticky_d;
  // Output stage
  logic        valid_out_q;
  logic [15:0] result_q, result_d;
  logic [7:0]        mant_r;
  logic signed [9:0] exp_r;
  logic              round_up;

`ifdef BF16_MUL_SPECIAL_EN
  logic s1_inf_a_q, s1_inf_b_q, s1_nan_a_q, s1_nan_b_q;
  logic s2_inf_q, s2_nan_q, s3_inf_q, s3_nan_q;
`endif

  assign advance   = out_ready | ~valid_out_q;
  assign in_ready  = advance;
  assign valid_out = valid_out_q;
  assign result    = result_q;

  assign s2_exp_d  = $signed({2'b00, s1_a_q[14:7]}) + $signed({2'b00, s1_b_q[14:7]}) - 10'sd127;
  assign s2_prod_d = {8'h00, 1'b1, s1_a_q[6:0]} * {8'h00, 1'b1, s1_b_q[6:0]};

  always_comb begin
    s3_mant_d   = s2_prod_q[13:7];
    s3_guard_d  = s2_prod_q[6];
    s3_sticky_d = |s2_prod_q[5:0];
    s3_exp_d    = s2_exp_q;
    if (s2_prod_q[15]) begin
      s3_mant_d   = s2_prod_q[14:8];
      s3_guard_d  = s2_prod_q[7];
      s3_sticky_d = |s2_prod_q[6:0];
      s3_exp_d    = s2_exp_q + 10'sd1;
    end
  end

  always_comb begin
    round_up = s3_guard_q & (s3_sticky_q | s3_mant_q[0]);
    mant_r   = {1'b0, s3_mant_q} + {7'h00, round_up};
    exp_r    = s3_exp_q + (mant_r[7] ? 10'sd1 : 10'sd0);
    result_d = {s3_sign_q, exp_r[7:0], (mant_r[7] ? 7'h00 : mant_r[6:0])};
    if (s3_zero_q || exp_r <= 10'sd0) begin
      result_d = {s3_sign_q, 15'h0000};
    end else if (exp_r >= 10'sd255) begin
`ifdef BF16_MUL_SPECIAL_EN
      result_d = {s3_sign_q, 8'hFF, 7'h00};
`else
      result_d = {s3_sign_q, 15'h7F7F};
`endif
    end
`ifdef BF16_MUL_SPECIAL_EN
    // NaN outranks zero so that Inf x 0 is not mistaken for a signed zero
    if (s3_nan_q) begin
      result_d = 16'h7FC0;
    end else if (s3_inf_q && !s3_zero_q) begin
      result_d = {s3_sign_q, 8'hFF, 7'h00};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= 16'h0000;
      s1_b_q      <= 16'h0000;
      s1_zero_a_q <= 1'b0;
      s1_zero_b_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_exp_q    <= 10'sd0;
      s2_prod_q   <= 16'h0000;
      s3_valid_q  <= 1'b0;
      s3_sign_q   <= 1'b0;
      s3_zero_q   <= 1'b0;
      s3_exp_q    <= 10'sd0;
      s3_mant_q   <= 7'h00;
      s3_guard_q  <= 1'b0;
      s3_sticky_q <= 1'b0;
      valid_out_q <= 1'b0;
      result_q    <= 16'h0000;
`ifdef BF16_MUL_SPECIAL_EN
      s1_inf_a_q  <= 1'b0;
      s1_inf_b_q  <= 1'b0;
      s1_nan_a_q  <= 1'b0;
      s1_nan_b_q  <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_nan_q    <= 1'b0;
      s3_inf_q    <= 1'b0;
      s3_nan_q    <= 1'b0;
`endif
    end else if (advance) begin
      s1_valid_q  <= valid_in;
      s1_a_q      <= a;
      s1_b_q      <= b;
      s1_zero_a_q <= (a[14:7] == 8'h00);
      s1_zero_b_q <= (b[14:7] == 8'h00);
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_a_q[15] ^ s1_b_q[15];
      s2_zero_q   <= s1_zero_a_q | s1_zero_b_q;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      s3_valid_q  <= s2_valid_q;
      s3_sign_q   <= s2_sign_q;
      s3_zero_q   <= s2_zero_q;
      s3_exp_q    <= s3_exp_d;
      s3_mant_q   <= s3_mant_d;
      s3_guard_q  <= s3_guard_d;
      s3_sticky_q <= s3_sticky_d;
      valid_out_q <= s3_valid_q;
      if (s3_valid_q) begin
        result_q <= result_d;
      end
`ifdef BF16_MUL_SPECIAL_EN
      s1_inf_a_q  <= (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      s1_inf_b_q  <= (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      s1_nan_a_q  <= (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      s1_nan_b_q  <= (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      s2_inf_q    <= s1_inf_a_q | s1_inf_b_q;
      s2_nan_q    <= s1_nan_a_q | s1_nan_b_q | (s1_inf_a_q & s1_zero_b_q) | (s1_inf_b_q & s1_zero_a_q);
      s3_inf_q    <= s2_inf_q;
      s3_nan_q    <= s2_nan_q;
`endif
    end
  end

endmodule

// File: tb/tb_bf16_multiplier_pipeline.sv
// Directed bench for bf16_multiplier_pipeline: products, rounding, zero/overflow, stall and reset.
module tb_bf16_multiplier_pipeline;

  logic        clk, rst_n, valid_in, in_ready, valid_out, out_ready;
  logic [15:0] a, b, result;
  int total, bad;

  localparam int NV = 19;
  localparam logic [15:0] VA [0:NV-1] = '{
    16'h3FC0, 16'hBF80, 16'h3FC1, 16'h3FFF, 16'h3FC0, 16'h3FC0, 16'h3FB5, 16'h8000,
    16'h0000, 16'h0080, 16'h0080, 16'h0040, 16'h7F7F, 16'h7F00, 16'hFF00, 16'h7F80,
    16'h7FC1, 16'hFF80, 16'h0000};
  localparam logic [15:0] VB [0:NV-1] = '{
    16'h4000, 16'h4040, 16'h3FC1, 16'h3FFF, 16'h3F83, 16'h3F81, 16'h3FB5, 16'h3F80,
    16'h4000, 16'h3F00, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 16'h4000, 16'h0000,
    16'h3F80, 16'h4000, 16'hFF80};
`ifdef BF16_MUL_SPECIAL_EN
  localparam logic [15:0] VE [0:NV-1] = '{
    16'h4040, 16'hC040, 16'h4012, 16'h407E, 16'h3FC4, 16'h3FC2, 16'h4000, 16'h8000,
    16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h7F7F, 16'h7F80, 16'hFF80, 16'h7FC0,
    16'h7FC0, 16'hFF80, 16'h7FC0};
`else
  localparam logic [15:0] VE [0:NV-1] = '{
    16'h4040, 16'hC040, 16'h4012, 16'h407E, 16'h3FC4, 16'h3FC2, 16'h4000, 16'h8000,
    16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h7F7F, 16'h7F7F, 16'hFF7F, 16'h0000,
    16'h7F7F, 16'hFF7F, 16'h8000};
`endif

  bf16_multiplier_pipeline dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
    .a(a), .b(b), .valid_out(valid_out), .out_ready(out_ready), .result(result));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task test_reset;
    rst_n = 1'b0; valid_in = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;
    #2;
    total++;
    if (valid_out !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got vo=%b res=%h rdy=%b want vo=0 res=0000 rdy=1", valid_out, result, in_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: got vo=%b rdy=%b want vo=0 rdy=1", valid_out, in_ready);
    end
  endtask

  task test_vectors;
    for (int i = 0; i < NV; i++) begin
      out_ready = 1'b1; valid_in = 1'b1; a = VA[i]; b = VB[i];
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        if (k == 2) begin
          total++;
          if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL vec%0d_early: valid_out got %b want 0 at N+2", i, valid_out);
          end
        end
      end
      total++;
      if (valid_out !== 1'b1 || result !== VE[i]) begin
        bad++;
        $display("FAIL vec%0d %h*%h: got vo=%b res=%h want vo=1 res=%h", i, VA[i], VB[i], valid_out, result, VE[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task test_backpressure;
    int n_in, n_out, stall;
    bit seen, acc;
    n_in = 0; n_out = 0; stall = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
      valid_in = (n_in < 5);
      if (n_in < 5) begin a = VA[n_in]; b = VB[n_in]; end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        total++;
        if (in_ready !== 1'b0 || valid_out !== 1'b1 || result !== VE[n_out]) begin
          bad++;
          $display("FAIL stall_hold: got rdy=%b vo=%b res=%h want rdy=0 vo=1 res=%h", in_ready, valid_out, result, VE[n_out]);
        end
      end
      if (valid_out && out_ready) begin
        total++;
        if (result !== VE[n_out]) begin
          bad++;
          $display("FAIL stream_out%0d: got %h want %h", n_out, result, VE[n_out]);
        end
        n_out++;
      end
      acc = valid_in && in_ready;
      @(posedge clk); #1;
      if (acc) n_in++;
      if (stall > 0) stall--;
      else if (!seen && valid_out) begin seen = 1'b1; stall = 4; end
    end
    valid_in = 1'b0; out_ready = 1'b1;
    total++;
    if (n_out != 5 || n_in != 5 || !seen) begin
      bad++;
      $display("FAIL stream_count: got in=%0d out=%0d want in=5 out=5", n_in, n_out);
    end
    #1;
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL stream_extra: valid_out got %b want 0 after last product", valid_out);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task test_reset_midstream;
    bit stale;
    out_ready = 1'b0; valid_in = 1'b1; a = VA[0]; b = VB[0];
    @(posedge clk); #1;
    a = VA[1]; b = VB[1];
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b1 || result !== VE[0]) begin
      bad++;
      $display("FAIL pre_reset_head: got vo=%b res=%h want vo=1 res=%h", valid_out, result, VE[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got vo=%b res=%h rdy=%b want vo=0 res=0000 rdy=1", valid_out, result, in_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL stale_product: got valid_out=1 after reset want 0");
    end
    valid_in = 1'b1; a = VA[2]; b = VB[2];
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_early: valid_out got %b want 0 at N+2", valid_out);
    end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b1 || result !== VE[2]) begin
      bad++;
      $display("FAIL post_reset_product: got vo=%b res=%h want vo=1 res=%h", valid_out, result, VE[2]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
